mux_2n_pipe: RTL and testbench
==============================

Name: mux_2n_pipe

Overview:
- Parametrised, pipelined 2^SEL_W:1 multiplexer built as a binary tree of 2:1 mux levels, with a register after every level.
- Successor to the fixed 4-bit 4:1 mux: width and input count are generalised, and it adds valid/ready flow control with full-pipeline stall.
- Used wherever a wide selection must close timing at high fan-in, for example channel selection ahead of a serialiser.

Parameters:
- WIDTH, 4, data width of each input channel and of y.
- SEL_W, 2, select width; input count N = 2**SEL_W; legal range 1..6 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  d and sel valid this cycle.
- in_ready  output  1  pipeline can accept; a transfer occurs when in_valid & in_ready.
- d  input  N*WIDTH  packed inputs; channel i = d[i*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index, sampled with d.
- out_valid  output  1  y holds a result.
- out_ready  input  1  downstream accepts; consumed when out_valid & out_ready.
- y  output  WIDTH  selected channel.

Behaviour:
- Structure: SEL_W levels. Level k takes 2**(SEL_W-k) operands and forms pairs (2j, 2j+1), selected by sel bit k (LSB first). Level 0 uses sel[0] on the raw inputs.
- Each level stage holds three registers: its data vector, the unused upper sel bits (sel[SEL_W-1:k+1]), and a valid bit.
- y and out_valid are driven directly from the last stage. There is no combinational path from d or sel to y.
- Global advance: adv = ~out_valid | out_ready. Also in_ready = adv. All stages move together.
- When adv=1:
  - Stage 0 valid <= in_valid.
  - Stage k valid <= stage k-1 valid.
  - Data and sel registers load only if the upstream valid is 1; otherwise they hold.
- When adv=0: every stage register holds. in_ready=0, so input is ignored even if in_valid=1.
- Latency: exactly SEL_W cycles from accepted input to out_valid, with no stalls. Throughput is 1 result per cycle while out_ready=1.
- Bubbles: an invalid cycle at the input propagates as a bubble and is never compressed.
- Selection uses ternary semantics. X or Z on an unselected channel must not reach y. X on a selected channel passes through unchanged.
- Reset (rst=0 at a clk edge):
  - All valid bits, data registers and sel registers clear to 0.
  - Outputs: out_valid=0, y=0. in_ready reads 1 (since out_valid=0).
  - Mid-operation reset discards all in-flight data. The first accepted input after release appears SEL_W cycles later.
- Simultaneous consume and accept: when out_valid=1 and out_ready=1, the last stage is replaced in the same edge. There is no bubble.
- out_valid and y must stay stable while out_valid=1 and out_ready=0.
- SEL_W=1 degenerates to a single registered 2:1 mux with latency 1.

Test Plan:
- WIDTH=4, SEL_W=2, out_ready=1. Channels d0..d3 = a,b,c,d; drive sel=0,1,2,3 on consecutive cycles with in_valid=1. Expect y = a,b,c,d on cycles 2,3,4,5 after the first, with out_valid high on 4 consecutive cycles.
- Channels d0..d3 = 7,10,3,X with sel=0,1,2 -> y = 7,10,3 with no X. With sel=3 -> y === X and out_valid=1.
- Back-pressure: stream sel=0..3, then hold out_ready=0 for 3 cycles once out_valid rises.
  - Expect in_ready=0, and y/out_valid frozen at a.
  - On release, expect b,c,d in order with no loss or duplication.
- Bubble: in_valid pattern 1,0,1 with sel 0,x,3 -> out_valid pattern 1,0,1 with y = a, then d.
- Reset mid-stream: after 2 accepted inputs, pull rst low for 1 cycle.
  - Expect out_valid=0, y=0 on the next cycle, and no result from the flushed inputs.
  - A new input with sel=2 gives y=c exactly 2 cycles after acceptance.
- WIDTH=8, SEL_W=3, channel i = 8'h10+i: sweep sel 7 down to 0 -> y = 17h..10h at latency 3.

Source files
------------

// File: rtl/mux_2n_pipe_if.sv
// Flow-controlled bus of the pipelined 2^SEL_W:1 multiplexer.
// The master drives the operands and the downstream ready signal.
// The slave (the mux) returns in_ready, out_valid and y.
interface mux_2n_pipe_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   d;
  logic [SEL_W-1:0]     sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;

  modport master (
    output in_valid, d, sel, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, d, sel, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/mux_2n_pipe.sv
// Pipelined 2^SEL_W:1 multiplexer.
// It is built as a binary tree of 2:1 levels with a register after each level.
// Level k resolves sel bit k, LSB first.
// All stages advance together whenever the output is empty or is being consumed.
// There is no combinational path from d/sel to y.
module mux_2n_pipe #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_2n_pipe_if.slave  bus
);
  localparam int N = 1 << SEL_W;

  // Every level's operand vector lives in one flat bus.
  // Segment k is the input of level k. Segment 0 is d itself.
  // The last segment is y.
  function automatic int doff(input int k);
    return (2*N - 2*(N >> k)) * WIDTH;
  endfunction

  // Remaining select bits use the same layout.
  // Segment k holds sel[SEL_W-1:k]. Its bit 0 drives level k.
  function automatic int soff(input int k);
    return k*SEL_W - (k*(k-1))/2;
  endfunction

  localparam int DTOT = (2*N - 1) * WIDTH;
  localparam int STOT = (SEL_W * (SEL_W + 1)) / 2;

  if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
    $error("mux_2n_pipe: SEL_W must be in 1..6");
  end

  logic [DTOT-1:0]  dflat;
  logic [STOT-1:0]  sflat;
  logic [SEL_W:0]   vchain;   // vchain[0] = in_valid, vchain[k+1] = stage k valid
  logic             adv;

  assign dflat[N*WIDTH-1:0] = bus.d;
  assign sflat[SEL_W-1:0]   = bus.sel;
  assign vchain[0]          = bus.in_valid;

  assign adv           = ~vchain[SEL_W] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vchain[SEL_W];
  assign bus.y         = dflat[doff(SEL_W) +: WIDTH];

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int unsigned NIN  = N >> k;
    localparam int unsigned NOUT = NIN / 2;
    localparam int          DI   = doff(k);
    localparam int          DO   = doff(k + 1);
    localparam int          SI   = soff(k);

    logic [NIN*WIDTH-1:0]  din;
    logic [NOUT*WIDTH-1:0] dmux;
    logic [NOUT*WIDTH-1:0] dq;
    logic                  sbit;
    logic                  vq;

    assign din  = dflat[DI +: NIN*WIDTH];
    assign sbit = sflat[SI];

    // Pairwise 2:1 selection. The ternary keeps an unselected X off the output.
    always_comb begin
      dmux = '0;
      for (int unsigned j = 0; j < NOUT; j++) begin
        dmux[j*WIDTH +: WIDTH] = sbit ? din[(2*j+1)*WIDTH +: WIDTH]
                                      : din[(2*j)*WIDTH +: WIDTH];
      end
    end

    // Stage register: valid follows upstream on advance, and data loads only with valid upstream.
    always_ff @(posedge clk) begin
      if (!rst) begin
        vq <= 1'b0;
        dq <= '0;
      end else if (adv) begin
        vq <= vchain[k];
        if (vchain[k]) begin
          dq <= dmux;
        end
      end
    end

    assign vchain[k+1]              = vq;
    assign dflat[DO +: NOUT*WIDTH]  = dq;

    if (k < SEL_W - 1) begin : g_sel
      localparam int SW = SEL_W - k - 1;
      localparam int SO = soff(k + 1);

      logic [SW-1:0] sq;

      // Carry the select bits still unused down to the next level.
      always_ff @(posedge clk) begin
        if (!rst) begin
          sq <= '0;
        end else if (adv && vchain[k]) begin
          sq <= sflat[SI+1 +: SW];
        end
      end

      assign sflat[SO +: SW] = sq;
    end
  end
endmodule

// File: tb/tb_mux_2n_pipe.sv
// Self-checking bench for mux_2n_pipe.
// It runs a 4-bit 4:1 instance and an 8-bit 8:1 instance.
// A queue model of the pipeline slots is compared with both DUTs every cycle.
// Directed sequences with literal expectations pin the model itself.
module tb_mux_2n_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_2n_pipe_if #(.WIDTH(4), .SEL_W(2)) ia ();
  mux_2n_pipe_if #(.WIDTH(8), .SEL_W(3)) ib ();

  mux_2n_pipe #(.WIDTH(4), .SEL_W(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mux_2n_pipe #(.WIDTH(8), .SEL_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  typedef struct packed {
    logic       v;
    logic [7:0] val;
  } item_t;

  // Front of each queue is the result currently presented at the output.
  item_t qa[$];
  item_t qb[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fixed-depth line of slots.
  // On advance, the oldest slot leaves and the selected channel enters.
  always @(posedge clk) begin
    if (!rst) begin
      qa.delete();
      repeat (2) qa.push_back('0);
      qb.delete();
      repeat (3) qb.push_back('0);
    end else begin
      if (!qa[0].v || ia.out_ready) begin
        void'(qa.pop_front());
        qa.push_back({ia.in_valid, 4'b0, ia.d[ia.sel*4 +: 4]});
      end
      if (!qb[0].v || ib.out_ready) begin
        void'(qb.pop_front());
        qb.push_back({ib.in_valid, ib.d[ib.sel*8 +: 8]});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_out_valid", {7'b0, ia.out_valid}, {7'b0, qa[0].v});
      chk("a_in_ready",  {7'b0, ia.in_ready},  {7'b0, (!qa[0].v || ia.out_ready)});
      if (qa[0].v) chk("a_y", {4'b0, ia.y}, qa[0].val);
      chk("b_out_valid", {7'b0, ib.out_valid}, {7'b0, qb[0].v});
      chk("b_in_ready",  {7'b0, ib.in_ready},  {7'b0, (!qb[0].v || ib.out_ready)});
      if (qb[0].v) chk("b_y", ib.y, qb[0].val);
    end
  end

  task automatic drv(input bit v, input logic [1:0] s, input bit ordy);
    #1;
    ia.in_valid  = v;
    ia.sel       = s;
    ia.out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic drvb(input bit v, input logic [2:0] s);
    #1;
    ib.in_valid = v;
    ib.sel      = s;
    @(negedge clk);
  endtask

  task automatic expa(input string nm, input bit ov, input logic [3:0] yv);
    chk({nm, "_ov"}, {7'b0, ia.out_valid}, {7'b0, ov});
    if (ov) chk({nm, "_y"}, {4'b0, ia.y}, {4'b0, yv});
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.sel = '0; ia.d = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.sel = '0; ib.d = '0; ib.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_ov", {7'b0, ia.out_valid}, 8'd0);
    chk("rst_a_y",  {4'b0, ia.y},         8'd0);
    chk("rst_a_ir", {7'b0, ia.in_ready},  8'd1);
    chk("rst_b_ov", {7'b0, ib.out_valid}, 8'd0);
    chk("rst_b_y",  ib.y,                 8'd0);
    chk("rst_b_ir", {7'b0, ib.in_ready},  8'd1);
    chk_on = 1'b1;
    #1 rst = 1'b1;

    // Streaming sel 0..3, latency 2
    ia.d = {4'hC, 4'h3, 4'hA, 4'h5};
    drv(1, 0, 1); expa("t1_lat", 0, 4'h0);
    drv(1, 1, 1); expa("t1_y0", 1, 4'h5);
    drv(1, 2, 1); expa("t1_y1", 1, 4'hA);
    drv(1, 3, 1); expa("t1_y2", 1, 4'h3);
    drv(0, 0, 1); expa("t1_y3", 1, 4'hC);
    drv(0, 0, 1); expa("t1_end", 0, 4'h0);

    // X on channel 3: blocked when unselected, passed when selected
    ia.d = {4'bxxxx, 4'd3, 4'd10, 4'd7};
    drv(1, 0, 1); expa("x_lat", 0, 4'h0);
    drv(1, 1, 1); expa("x_y0", 1, 4'd7);
    drv(1, 2, 1); expa("x_y1", 1, 4'd10);
    drv(1, 3, 1); expa("x_y2", 1, 4'd3);
    drv(0, 0, 1); expa("x_y3", 1, 4'bxxxx);
    drv(0, 0, 1); expa("x_end", 0, 4'h0);

    // Back-pressure: hold for 3 cycles once a result is presented
    ia.d = {4'hC, 4'h3, 4'hA, 4'h5};
    drv(1, 0, 1);
    drv(1, 1, 1); expa("bp_a", 1, 4'h5);
    repeat (3) begin
      drv(1, 2, 0); expa("bp_hold", 1, 4'h5);
      chk("bp_ir", {7'b0, ia.in_ready}, 8'd0);
    end
    drv(1, 2, 1); expa("bp_b", 1, 4'hA);
    drv(1, 3, 1); expa("bp_c", 1, 4'h3);
    drv(0, 0, 1); expa("bp_d", 1, 4'hC);
    drv(0, 0, 1); expa("bp_end", 0, 4'h0);

    // Bubble is propagated, not compressed
    drv(1, 0, 1); expa("bub_0", 0, 4'h0);
    drv(0, 1, 1); expa("bub_a", 1, 4'h5);
    drv(1, 3, 1); expa("bub_gap", 0, 4'h0);
    drv(0, 0, 1); expa("bub_d", 1, 4'hC);
    drv(0, 0, 1); expa("bub_end", 0, 4'h0);

    // Reset mid-stream flushes in-flight data
    drv(1, 0, 1);
    drv(1, 1, 1); expa("mrst_pre", 1, 4'h5);
    #1; rst = 1'b0; ia.in_valid = 1'b0;
    @(negedge clk);
    expa("mrst_ov", 0, 4'h0);
    chk("mrst_y", {4'b0, ia.y}, 8'd0);
    #1 rst = 1'b1;
    drv(1, 2, 1); expa("mrst_flushed", 0, 4'h0);
    drv(0, 0, 1); expa("mrst_c", 1, 4'h3);
    drv(0, 0, 1); expa("mrst_end", 0, 4'h0);

    // 8:1 instance: sweep sel 7..0, latency 3
    for (int i = 0; i < 8; i++) ib.d[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 10; i++) begin
      drvb(i < 8, 3'(7 - i));
      if (i >= 2) begin
        chk("b8_ov", {7'b0, ib.out_valid}, 8'd1);
        chk("b8_y", ib.y, 8'(8'h17 - (i - 2)));
      end else begin
        chk("b8_lat", {7'b0, ib.out_valid}, 8'd0);
      end
    end
    drvb(0, 0);
    chk("b8_end", {7'b0, ib.out_valid}, 8'd0);

    // Randomized traffic on both instances, with occasional reset
    for (int n = 0; n < 3000; n++) begin
      #1;
      rst          = ($urandom_range(0, 99) != 0);
      ia.in_valid  = 1'($urandom);
      ia.sel       = 2'($urandom);
      ia.d         = 16'($urandom);
      ia.out_ready = ($urandom_range(0, 3) != 0);
      ib.in_valid  = 1'($urandom);
      ib.sel       = 3'($urandom);
      ib.d         = {$urandom, $urandom};
      ib.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    #1;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
